// File: rtl/rx78_pkg.sv
// rtl/rx78_pkg.sv - shared VRAM geometry, arbiter state encoding and plane indices
package rx78_pkg;

  localparam int VRAM_ADDR_W = 13;
  localparam int VRAM_DATA_W = 8;
  localparam int VRAM_PLANES = 6;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    VID_LAT   = 2'd1,
    CPU_LAT   = 2'd2,
    CPU_WDONE = 2'd3
  } vram_state_e;

  // Bank mask bit i selects plane i: fg planes first, then bg.
  localparam int FG1 = 0;
  localparam int FG2 = 1;
  localparam int FG3 = 2;
  localparam int BG1 = 3;
  localparam int BG2 = 4;
  localparam int BG3 = 5;

endpackage

// File: rtl/vram_arbiter_if.sv
// rtl/vram_arbiter_if.sv - CPU, video-fetch and plane-RAM signals of the VRAM arbiter
interface vram_arbiter_if import rx78_pkg::*; #(
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int DATA_W = VRAM_DATA_W,
  parameter int PLANES = VRAM_PLANES
) ();

  logic                     cpu_req;
  logic                     cpu_wr;
  logic [ADDR_W-1:0]        cpu_addr;
  logic [DATA_W-1:0]        cpu_din;
  logic [PLANES-1:0]        rd_bank;
  logic [PLANES-1:0]        wr_bank;
  logic [DATA_W-1:0]        cpu_dout;
  logic                     cpu_ack;
  logic                     cpu_wait_n;
  logic                     vid_req;
  logic [ADDR_W-1:0]        vid_addr;
  logic [PLANES*DATA_W-1:0] vid_data;
  logic                     vid_valid;
  logic                     vid_overrun;
  logic [ADDR_W-1:0]        mem_addr;
  logic [DATA_W-1:0]        mem_din;
  logic [PLANES-1:0]        mem_we;
  logic [PLANES*DATA_W-1:0] mem_q;

  modport slave (
    input  cpu_req, cpu_wr, cpu_addr, cpu_din, rd_bank, wr_bank,
    output cpu_dout, cpu_ack, cpu_wait_n,
    input  vid_req, vid_addr,
    output vid_data, vid_valid, vid_overrun,
    output mem_addr, mem_din, mem_we,
    input  mem_q
  );

  modport master (
    output cpu_req, cpu_wr, cpu_addr, cpu_din, rd_bank, wr_bank,
    input  cpu_dout, cpu_ack, cpu_wait_n,
    output vid_req, vid_addr,
    input  vid_data, vid_valid, vid_overrun,
    input  mem_addr, mem_din, mem_we,
    output mem_q
  );

endinterface

// File: rtl/vram_plane_mux.sv
// rtl/vram_plane_mux.sv - OR of the plane bytes selected by the CPU read bank mask
module vram_plane_mux import rx78_pkg::*; #(
  parameter int DATA_W = VRAM_DATA_W,
  parameter int PLANES = VRAM_PLANES
) (
  input  logic [PLANES*DATA_W-1:0] i_mem_q,
  input  logic [PLANES-1:0]        i_rd_bank,
  output logic [DATA_W-1:0]        o_rd_byte
);

  always_comb begin
    o_rd_byte = '0;
    for (int i = 0; i < PLANES; i++) begin
      if (i_rd_bank[i]) o_rd_byte = o_rd_byte | i_mem_q[i*DATA_W +: DATA_W];
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - time-shares the single-port VRAM planes between the Z80 and video fetch
module vram_arbiter import rx78_pkg::*; #(
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int DATA_W = VRAM_DATA_W,
  parameter int PLANES = VRAM_PLANES
) (
  input  logic           clk,
  input  logic           reset,
  vram_arbiter_if.slave  bus
);

  vram_state_e              r_state;
  logic                     r_vid_pend;
  logic [ADDR_W-1:0]        r_vid_addr_q;
  logic                     r_cpu_prio;
  logic                     r_cpu_done;
  logic                     r_vid_overrun;
  logic                     r_cpu_ack;
  logic                     r_vid_valid;
  logic [DATA_W-1:0]        r_cpu_dout;
  logic [PLANES*DATA_W-1:0] r_vid_data;

  logic                     w_cpu_pend;
  logic                     w_idle;
  logic                     w_issue_vid;
  logic                     w_issue_rd;
  logic                     w_issue_wr;
  logic [DATA_W-1:0]        w_rd_byte;

  // Once acked, the CPU must drop req before it is seen as a new access.
  assign w_cpu_pend  = bus.cpu_req & ~r_cpu_done;
  assign w_idle      = (r_state == IDLE) & ~reset;
  assign w_issue_vid = w_idle & r_vid_pend & ~(r_cpu_prio & w_cpu_pend);
  assign w_issue_rd  = w_idle & ~w_issue_vid & w_cpu_pend & ~bus.cpu_wr;
  assign w_issue_wr  = w_idle & ~w_issue_vid & w_cpu_pend & bus.cpu_wr;

  // The RAM registers its address at the end of the issue cycle, so the
  // memory side is driven straight from the issue decision.
  always_comb begin
    bus.mem_addr = '0;
    bus.mem_din  = '0;
    bus.mem_we   = '0;
    if (w_issue_vid) begin
      bus.mem_addr = r_vid_addr_q;
    end else if (w_issue_rd || w_issue_wr) begin
      bus.mem_addr = bus.cpu_addr;
    end
    if (w_issue_wr) begin
      bus.mem_din = bus.cpu_din;
      bus.mem_we  = bus.wr_bank;
    end
  end

  vram_plane_mux #(
    .DATA_W (DATA_W),
    .PLANES (PLANES)
  ) u_plane_mux (
    .i_mem_q   (bus.mem_q),
    .i_rd_bank (bus.rd_bank),
    .o_rd_byte (w_rd_byte)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_vid_pend    <= 1'b0;
      r_vid_addr_q  <= '0;
      r_cpu_prio    <= 1'b0;
      r_cpu_done    <= 1'b0;
      r_vid_overrun <= 1'b0;
      r_cpu_ack     <= 1'b0;
      r_vid_valid   <= 1'b0;
      r_cpu_dout    <= '0;
      r_vid_data    <= '0;
    end else begin
      r_cpu_ack   <= 1'b0;
      r_vid_valid <= 1'b0;
      if (!bus.cpu_req) r_cpu_done <= 1'b0;

      // A request only counts as lost if the previous one is still unissued.
      if (bus.vid_req) begin
        r_vid_pend   <= 1'b1;
        r_vid_addr_q <= bus.vid_addr;
        if (r_vid_pend && !w_issue_vid) r_vid_overrun <= 1'b1;
      end else if (w_issue_vid) begin
        r_vid_pend <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (w_issue_vid)     r_state <= VID_LAT;
          else if (w_issue_rd) r_state <= CPU_LAT;
          else if (w_issue_wr) r_state <= CPU_WDONE;
        end
        VID_LAT: begin
          r_vid_data  <= bus.mem_q;
          r_vid_valid <= 1'b1;
          r_cpu_prio  <= w_cpu_pend;
          r_state     <= IDLE;
        end
        CPU_LAT: begin
          r_cpu_dout <= w_rd_byte;
          r_cpu_ack  <= 1'b1;
          r_cpu_done <= 1'b1;
          r_cpu_prio <= 1'b0;
          r_state    <= IDLE;
        end
        CPU_WDONE: begin
          r_cpu_ack  <= 1'b1;
          r_cpu_done <= 1'b1;
          r_cpu_prio <= 1'b0;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.cpu_dout    = r_cpu_dout;
  assign bus.cpu_ack     = r_cpu_ack;
  assign bus.cpu_wait_n  = ~w_cpu_pend;
  assign bus.vid_data    = r_vid_data;
  assign bus.vid_valid   = r_vid_valid;
  assign bus.vid_overrun = r_vid_overrun;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - directed bench with a slot-level arbiter model and plane RAMs
module tb_vram_arbiter;
  import rx78_pkg::*;

  localparam int AW = 13;
  localparam int DW = 8;
  localparam int NP = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .PLANES(NP)) bus ();

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PLANES(NP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  // Plane RAMs with one-cycle read latency, plus the model's shadow copy.
  logic [7:0] ram [NP][8192];
  logic [7:0] sh  [NP][8192];
  logic [7:0] q   [NP];

  for (genvar g = 0; g < NP; g++) begin : g_q
    assign bus.mem_q[g*8 +: 8] = q[g];
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < NP; i++) begin
      if (bus.mem_we[i]) ram[i][bus.mem_addr] <= bus.mem_din;
      q[i] <= ram[i][bus.mem_addr];
    end
  end

  function automatic logic [7:0] init_byte(int p, int a);
    return 8'((p * 37 + a * 11 + (a >> 8) * 5 + 3) & 255);
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // Model: an access occupies two cycles; m_kind is the access in its second cycle.
  bit          m_vpend = 0, m_over = 0, m_prio = 0, m_done = 0;
  logic [12:0] m_vaddr = '0, m_saddr = '0;
  int          m_kind = 0;
  logic        e_ack = 0, e_valid = 0;
  logic [7:0]  e_dout = '0;
  logic [47:0] e_vdata = '0;

  int          we_cyc = 0, wait_lo = 0, ack_cnt = 0;
  logic [5:0]  last_we = '0;
  int          vcyc[$];

  always @(negedge clk) begin : model
    bit          c_pend;
    int          d;
    logic [12:0] xa;
    logic [7:0]  xd;
    logic [5:0]  xw;
    c_pend = bus.cpu_req && !m_done;
    d = 0;
    if (!reset && m_kind == 0) begin
      if (m_vpend && !(m_prio && c_pend)) d = 1;
      else if (c_pend) d = bus.cpu_wr ? 3 : 2;
    end
    xa = (d == 1) ? m_vaddr : ((d >= 2) ? bus.cpu_addr : 13'd0);
    xd = (d == 3) ? bus.cpu_din : 8'd0;
    xw = (d == 3) ? bus.wr_bank : 6'd0;
    if (chk_en) begin
      chk("mem_addr", 64'(bus.mem_addr), 64'(xa));
      chk("mem_din", 64'(bus.mem_din), 64'(xd));
      chk("mem_we", 64'(bus.mem_we), 64'(xw));
      chk("cpu_wait_n", 64'(bus.cpu_wait_n), 64'(!c_pend));
      chk("cpu_ack", 64'(bus.cpu_ack), 64'(e_ack));
      chk("cpu_dout", 64'(bus.cpu_dout), 64'(e_dout));
      chk("vid_valid", 64'(bus.vid_valid), 64'(e_valid));
      chk("vid_data", 64'(bus.vid_data), 64'(e_vdata));
      chk("vid_overrun", 64'(bus.vid_overrun), 64'(m_over));
      if (bus.mem_we != 0) begin we_cyc++; last_we = bus.mem_we; end
      if (!bus.cpu_wait_n) wait_lo++;
      if (bus.cpu_ack) ack_cnt++;
      if (bus.vid_valid) vcyc.push_back(cyc);
    end
    if (reset) begin
      m_vpend = 0; m_over = 0; m_prio = 0; m_done = 0; m_kind = 0;
      e_ack = 0; e_valid = 0; e_dout = '0; e_vdata = '0;
    end else begin
      e_ack = 0;
      e_valid = 0;
      if (!bus.cpu_req) m_done = 0;
      case (m_kind)
        1: begin
          e_valid = 1;
          for (int i = 0; i < NP; i++) e_vdata[i*8 +: 8] = sh[i][m_saddr];
          m_prio = c_pend;
        end
        2: begin
          e_dout = '0;
          for (int i = 0; i < NP; i++) if (bus.rd_bank[i]) e_dout = e_dout | sh[i][m_saddr];
          e_ack = 1; m_done = 1; m_prio = 0;
        end
        3: begin
          e_ack = 1; m_done = 1; m_prio = 0;
        end
        default: ;
      endcase
      m_kind = d;
      if (d == 1) begin m_vpend = 0; m_saddr = m_vaddr; end
      if (d >= 2) m_saddr = bus.cpu_addr;
      if (d == 3) for (int i = 0; i < NP; i++) if (bus.wr_bank[i]) sh[i][bus.cpu_addr] = bus.cpu_din;
      if (bus.vid_req) begin
        if (m_vpend) m_over = 1;
        m_vpend = 1;
        m_vaddr = bus.vid_addr;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_go(bit wr, logic [12:0] a, logic [7:0] din, logic [5:0] rb, logic [5:0] wb);
    bus.cpu_wr   = wr;
    bus.cpu_addr = a;
    bus.cpu_din  = din;
    bus.rd_bank  = rb;
    bus.wr_bank  = wb;
    bus.cpu_req  = 1'b1;
  endtask

  task automatic wait_ack(string name, output int at);
    int n;
    n = 0;
    at = -1;
    while (n < 12 && !bus.cpu_ack) begin tick(); n++; end
    if (bus.cpu_ack) at = cyc;
    else begin
      total++; bad++;
      $display("FAIL %s_timeout cyc=%0d got=no_ack want=ack", name, cyc);
    end
  endtask

  int at, c0, w0, a0, n0;

  initial begin
    for (int i = 0; i < NP; i++)
      for (int a = 0; a < 8192; a++) begin
        ram[i][a] = init_byte(i, a);
        sh[i][a]  = init_byte(i, a);
      end
    ram[1][13'h200] = 8'h0F; sh[1][13'h200] = 8'h0F;
    ram[2][13'h200] = 8'hF0; sh[2][13'h200] = 8'hF0;
    bus.cpu_req = 0; bus.cpu_wr = 0; bus.cpu_addr = '0; bus.cpu_din = '0;
    bus.rd_bank = '0; bus.wr_bank = '0; bus.vid_req = 0; bus.vid_addr = '0;

    tick(); chk_en = 1; tick();
    chk("rst_wait_n", 64'(bus.cpu_wait_n), 64'd1);
    chk("rst_mem_we", 64'(bus.mem_we), 64'd0);
    chk("rst_ack", 64'(bus.cpu_ack), 64'd0);
    chk("rst_overrun", 64'(bus.vid_overrun), 64'd0);
    reset = 0; tick();

    // write 0xA5 to planes 0 and 2
    w0 = we_cyc; c0 = cyc;
    cpu_go(1, 13'h0123, 8'hA5, 6'b000000, 6'b000101);
    wait_ack("wr1", at);
    chk("wr1_lat", 64'(at - c0), 64'd2);
    chk("wr1_we_cycles", 64'(we_cyc - w0), 64'd1);
    chk("wr1_we_val", 64'(last_we), 64'h05);
    bus.cpu_req = 0; tick();
    cpu_go(0, 13'h0123, 8'h00, 6'b000001, 6'b000000);
    wait_ack("rd_a5", at);
    chk("rd_a5", 64'(bus.cpu_dout), 64'hA5);
    bus.cpu_req = 0; tick();

    // two-plane OR read
    w0 = wait_lo; c0 = cyc;
    cpu_go(0, 13'h0200, 8'h00, 6'b000110, 6'b000000);
    wait_ack("rd_ff", at);
    chk("rd_ff", 64'(bus.cpu_dout), 64'hFF);
    chk("rd_ff_lat", 64'(at - c0), 64'd2);
    chk("rd_ff_wait_n_at_ack", 64'(bus.cpu_wait_n), 64'd1);
    bus.cpu_req = 0; tick();
    chk("rd_ff_wait_lo", 64'(wait_lo - w0), 64'd2);

    // empty read mask
    cpu_go(0, 13'h0200, 8'h00, 6'b000000, 6'b000000);
    wait_ack("rd_zero", at);
    chk("rd_zero", 64'(bus.cpu_dout), 64'd0);
    bus.cpu_req = 0; tick();

    // video and CPU contend; second fetch arrives during the first
    bus.vid_req = 1; bus.vid_addr = 13'h0300; tick();
    bus.vid_req = 0; c0 = cyc; n0 = vcyc.size();
    cpu_go(0, 13'h0123, 8'h00, 6'b000001, 6'b000000);
    tick();
    bus.vid_req = 1; bus.vid_addr = 13'h0400; tick();
    bus.vid_req = 0;
    wait_ack("sc", at);
    chk("sc_ack_lat", 64'(at - c0), 64'd4);
    bus.cpu_req = 0;
    repeat (4) tick();
    chk("sc_vcount", 64'(vcyc.size() - n0), 64'd2);
    if (vcyc.size() >= n0 + 2) begin
      chk("sc_v1_lat", 64'(vcyc[n0] - c0), 64'd2);
      chk("sc_v2_lat", 64'(vcyc[n0+1] - c0), 64'd6);
    end
    chk("sc_vdata_p3", 64'(bus.vid_data[3*8 +: 8]), 64'(init_byte(3, 13'h0400)));

    // two fetch requests while a write is in flight
    n0 = vcyc.size();
    cpu_go(1, 13'h0777, 8'h3C, 6'b000000, 6'b111111);
    bus.vid_req = 1; bus.vid_addr = 13'h0500; tick();
    bus.vid_addr = 13'h0600; tick();
    bus.vid_req = 0;
    wait_ack("ov", at);
    bus.cpu_req = 0;
    repeat (5) tick();
    chk("ov_flag", 64'(bus.vid_overrun), 64'd1);
    chk("ov_vcount", 64'(vcyc.size() - n0), 64'd1);
    chk("ov_vdata_p0", 64'(bus.vid_data[7:0]), 64'(init_byte(0, 13'h0600)));

    // reset while a read is in its latency cycle
    cpu_go(0, 13'h0123, 8'h00, 6'b000001, 6'b000000);
    tick();
    reset = 1; bus.cpu_req = 0; a0 = ack_cnt; w0 = we_cyc;
    tick();
    chk("rst_mid_ack", 64'(bus.cpu_ack), 64'd0);
    chk("rst_mid_wait_n", 64'(bus.cpu_wait_n), 64'd1);
    chk("rst_mid_dout", 64'(bus.cpu_dout), 64'd0);
    chk("rst_mid_vdata", 64'(bus.vid_data), 64'd0);
    chk("rst_mid_overrun", 64'(bus.vid_overrun), 64'd0);
    tick(); reset = 0; tick();
    chk("rst_mid_no_ack", 64'(ack_cnt - a0), 64'd0);
    chk("rst_mid_no_we", 64'(we_cyc - w0), 64'd0);

    // held request with an empty write mask
    a0 = ack_cnt; w0 = we_cyc;
    cpu_go(1, 13'h0123, 8'h55, 6'b000000, 6'b000000);
    wait_ack("hold", at);
    repeat (5) tick();
    chk("hold_one_ack", 64'(ack_cnt - a0), 64'd1);
    chk("hold_no_we", 64'(we_cyc - w0), 64'd0);
    chk("hold_wait_n", 64'(bus.cpu_wait_n), 64'd1);
    bus.cpu_req = 0; tick();
    cpu_go(0, 13'h0123, 8'h00, 6'b000001, 6'b000000);
    wait_ack("hold_rd", at);
    chk("hold_rd_a5", 64'(bus.cpu_dout), 64'hA5);
    bus.cpu_req = 0;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Time-shares the six single-port 8K VRAM planes between the Z80 and the video fetch. Planes 1-3 are fg, 4-6 are bg.
- CPU accesses use the per-plane read and write bank masks from I/O ports F1/F2. The CPU is stalled via a wait line while video owns the memory.
- Sits between tv80s/gfx and the plane RAMs, replacing the dual-port VRAM.

Parameters:
- ADDR_W, 13, plane address width.
- DATA_W, 8, plane data width.
- PLANES, 6, number of VRAM planes (bank mask bit i selects plane i).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  level; CPU VRAM access pending (held until cpu_ack)
- cpu_wr  in  1  1 = write, 0 = read; valid with cpu_req
- cpu_addr  in  ADDR_W  CPU plane address
- cpu_din  in  DATA_W  CPU write data
- rd_bank  in  PLANES  read plane mask
- wr_bank  in  PLANES  write plane mask
- cpu_dout  out  DATA_W  OR of selected planes' read data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_wait_n  out  1  low while the CPU access is unserved
- vid_req  in  1  one-cycle fetch request pulse
- vid_addr  in  ADDR_W  fetch address, sampled with vid_req
- vid_data  out  PLANES*DATA_W  all planes' bytes; plane i at [i*8+:8]
- vid_valid  out  1  one-cycle pulse when vid_data updates
- vid_overrun  out  1  sticky; fetch request lost
- mem_addr  out  ADDR_W  shared plane address
- mem_din  out  DATA_W  shared write data
- mem_we  out  PLANES  per-plane write enable
- mem_q  in  PLANES*DATA_W  plane read data, 1-cycle latency

Behaviour:
- Reset values: state IDLE; all outputs 0 except cpu_wait_n=1. vid_pend, cpu_prio, cpu_done and vid_overrun are cleared.
- vid_req latches vid_addr into vid_pend/vid_addr_q.
  - vid_req while vid_pend is set: the new address overwrites the old one and vid_overrun sets. vid_overrun is cleared only by reset.
- cpu_wait_n = ~(cpu_req & ~cpu_done), combinational. It is high in the cycle cpu_ack is asserted.
- cpu_done:
  - sets with cpu_ack and clears when cpu_req=0.
  - While it is set, cpu_req is ignored. The CPU must drop req for at least one cycle between accesses.
- FSM states: IDLE, VID_LAT, CPU_LAT, CPU_WDONE.
- IDLE:
  - if vid_pend and not (cpu_prio and cpu pending): drive mem_addr=vid_addr_q, mem_we=0, clear vid_pend, go to VID_LAT.
  - else if cpu pending, read: drive mem_addr=cpu_addr, go to CPU_LAT.
  - else if cpu pending, write: drive mem_addr=cpu_addr, mem_din=cpu_din, mem_we=wr_bank for exactly this one cycle, go to CPU_WDONE.
  - A vid_req in the same cycle is latched but not issued this cycle.
- VID_LAT:
  - vid_data <= mem_q; vid_valid=1 for one cycle.
  - cpu_prio <= cpu pending.
  - go to IDLE.
- CPU_LAT:
  - cpu_dout <= OR over i of (rd_bank[i] ? mem_q plane i : 0).
  - cpu_ack=1, clear cpu_prio, go to IDLE.
- CPU_WDONE: cpu_ack=1, clear cpu_prio, go to IDLE.
- Bank mask cases:
  - wr_bank=0: no plane is written; ack still occurs.
  - rd_bank=0: cpu_dout=0.
- Simultaneous new cpu_req and vid_pend in IDLE with cpu_prio=0: video wins. The CPU is then guaranteed the next slot.
- Every access takes 2 cycles.
  - Worst-case video latency is 4 cycles (CPU access in flight).
  - Worst-case CPU latency is 4 cycles, because cpu_prio prevents starvation.
- mem_we is never asserted outside the single IDLE write-issue cycle.
- Reset mid-access returns to IDLE. No ack or vid_valid is issued for the aborted access.
- vid_data and cpu_dout hold their last value between updates.

Decomposition:
- Shared package rx78_pkg holds:
  - VRAM_ADDR_W=13, VRAM_DATA_W=8, VRAM_PLANES=6.
  - The state enum {IDLE, VID_LAT, CPU_LAT, CPU_WDONE}.
  - Plane index constants FG1..BG3 = 0..5.
- One natural sub-module, vram_plane_mux: the combinational rd_bank-masked OR reduction of mem_q.

Test Plan:
- Write with wr_bank=6'b000101, addr 0x0123, din 0xA5:
  - mem_we=000101 for exactly 1 cycle.
  - cpu_ack 2 cycles after req.
  - A later read with rd_bank=000001 returns 0xA5.
- Read with rd_bank=000110, plane2=0x0F, plane3=0xF0 (model) -> cpu_dout=0xFF, cpu_wait_n low for 2 cycles then high with ack.
- vid_req and cpu_req in the same cycle:
  - vid_valid at cycle +2.
  - cpu_ack at cycle +4, even if a second vid_req arrives at cycle +1.
  - That second fetch is then served after the CPU access.
- Two vid_req pulses before service (CPU write in flight) -> vid_overrun=1; the fetch uses the second address only; a single vid_valid.
- Reset asserted during CPU_LAT -> no cpu_ack, no mem_we, outputs zero, cpu_wait_n=1.
- cpu_req held high after ack -> no second access until req drops for ≥1 cycle; wr_bank=0 write acks with mem_we=0.
